// File: rtl/aes_stim_seq_if.sv
// aes_stim_seq_if: command, DUT-drive, DUT-result and statistics bundle for aes_stim_seq
// master: stimulus source / DUT side (drives cmd_*, res_*, stat_clear)
// slave : aes_stim_seq (drives cmd_ready, dut_*, busy, done, *_cnt)
interface aes_stim_seq_if #(
  parameter int KEY_SIZE = 128,
  parameter int CNT_W    = 16
);
  logic                cmd_valid, cmd_ready, cmd_type;
  logic [127:0]        cmd_plain, cmd_cipher;
  logic [KEY_SIZE-1:0] cmd_key;
  logic                dut_valid, dut_flush;
  logic [127:0]        dut_plain;
  logic [KEY_SIZE-1:0] dut_key;
  logic                res_valid;
  logic [127:0]        res_data;
  logic                stat_clear, busy, done;
  logic [CNT_W-1:0]    mismatch_cnt, weak_cnt, missing_cnt;
  modport master (
    output cmd_valid, cmd_type, cmd_plain, cmd_cipher, cmd_key, res_valid, res_data, stat_clear,
    input  cmd_ready, dut_valid, dut_flush, dut_plain, dut_key, busy, done,
           mismatch_cnt, weak_cnt, missing_cnt
  );
  modport slave (
    input  cmd_valid, cmd_type, cmd_plain, cmd_cipher, cmd_key, res_valid, res_data, stat_clear,
    output cmd_ready, dut_valid, dut_flush, dut_plain, dut_key, busy, done,
           mismatch_cnt, weak_cnt, missing_cnt
  );
endinterface

// File: rtl/aes_stim_seq.sv
// aes_stim_seq: AES DUT stimulus sequencer with directed checks and bit-flip avalanche sweeps
// clk, rst_n : clock, asynchronous active-low reset
// io_bus     : cmd_* command in, dut_* vector out, res_* result in, stat_clear/busy/done, counters out
module aes_stim_seq #(
  parameter int KEY_SIZE = 128,
  parameter int LATENCY  = 10,
  parameter int FLIP_KEY = 1,
  parameter int AVAL_MIN = 32,
  parameter int CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  aes_stim_seq_if.slave io_bus
);
  typedef enum logic [2:0] {IDLE, FLUSH, BASE, SWEEP_P, SWEEP_K, DRAIN} state_t;
  localparam logic [1:0] K_DIR = 2'd0, K_BASE = 2'd1, K_FLIP = 2'd2;
  localparam int TW = 131;
  state_t              r_state, w_next;
  logic [7:0]          r_idx;
  logic                r_dv;
  logic [127:0]        r_dp, r_dc, r_p, r_base;
  logic [KEY_SIZE-1:0] r_dk, r_k;
  logic [TW-1:0]       r_tag [LATENCY];
  logic [CNT_W-1:0]    r_mm, r_wk, r_ms;
  logic                w_acc, w_seed, w_clr, w_empty, w_hit, w_miss, w_mis, w_weak, w_bcap;
  logic [1:0]          w_kind;
  logic [7:0]          w_pop;
  logic [TW-1:0]       w_out;
  assign io_bus.cmd_ready = rst_n & (r_state == IDLE);
  assign w_acc  = io_bus.cmd_valid & io_bus.cmd_ready;
  assign w_seed = w_acc & io_bus.cmd_type;
  // a new seeded run discards everything still in flight
  assign w_clr  = w_seed | (r_state == FLUSH);
  always_comb begin
    w_empty = 1'b1;
    for (int i = 0; i < LATENCY; i++) w_empty = w_empty & ~r_tag[i][TW-1];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_seed) w_next = FLUSH;
      FLUSH:   if (r_idx[0]) w_next = BASE;
      BASE:    w_next = SWEEP_P;
      SWEEP_P: if (r_idx == 8'd127) w_next = FLIP_KEY != 0 ? SWEEP_K : DRAIN;
      SWEEP_K: if (r_idx == 8'(KEY_SIZE - 1)) w_next = DRAIN;
      DRAIN:   if (w_empty) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    io_bus.dut_flush = r_state == FLUSH;
    io_bus.done      = (r_state == DRAIN) & w_empty;
    io_bus.busy      = (r_state != IDLE) | ~w_empty;
    io_bus.dut_valid = r_state == IDLE ? r_dv : r_state inside {BASE, SWEEP_P, SWEEP_K};
    io_bus.dut_plain = r_state == IDLE ? r_dp : r_p ^ (r_state == SWEEP_P ? 128'(1) << r_idx : '0);
    io_bus.dut_key   = r_state == IDLE ? r_dk : r_k ^ (r_state == SWEEP_K ? KEY_SIZE'(1) << r_idx : '0);
    w_kind           = r_state == IDLE ? K_DIR : r_state == BASE ? K_BASE : K_FLIP;
  end
  // oldest tag lines up with the result of the vector launched LATENCY cycles ago
  assign w_out  = r_tag[LATENCY-1];
  assign w_pop  = 8'($countones(io_bus.res_data ^ r_base));
  assign w_hit  = w_out[TW-1] & io_bus.res_valid;
  assign w_miss = w_out[TW-1] & ~io_bus.res_valid;
  assign w_mis  = w_hit && w_out[129:128] == K_DIR && io_bus.res_data != w_out[127:0];
  assign w_weak = w_hit && w_out[129:128] == K_FLIP && w_pop < 8'(AVAL_MIN);
  assign w_bcap = w_hit && w_out[129:128] == K_BASE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_next != r_state ? '0 : r_idx + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv   <= 1'b0;
      r_dp   <= '0;
      r_dk   <= '0;
      r_dc   <= '0;
      r_p    <= '0;
      r_k    <= '0;
      r_base <= '0;
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_dv <= w_acc & ~io_bus.cmd_type;
      if (w_acc & ~io_bus.cmd_type) begin
        r_dp <= io_bus.cmd_plain;
        r_dk <= io_bus.cmd_key;
        r_dc <= io_bus.cmd_cipher;
      end
      if (w_seed) begin
        r_p <= io_bus.cmd_plain;
        r_k <= io_bus.cmd_key;
      end
      if (w_bcap) r_base <= io_bus.res_data;
      for (int i = LATENCY - 1; i > 0; i--) r_tag[i] <= w_clr ? '0 : r_tag[i-1];
      r_tag[0] <= w_clr ? '0 : {io_bus.dut_valid, w_kind, r_dc};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mm <= '0;
      r_wk <= '0;
      r_ms <= '0;
    end else begin
      r_mm <= io_bus.stat_clear ? '0 : r_mm + CNT_W'(w_mis & ~&r_mm);
      r_wk <= io_bus.stat_clear ? '0 : r_wk + CNT_W'(w_weak & ~&r_wk);
      r_ms <= io_bus.stat_clear ? '0 : r_ms + CNT_W'(w_miss & ~&r_ms);
    end
  end
  assign io_bus.mismatch_cnt = r_mm;
  assign io_bus.weak_cnt     = r_wk;
  assign io_bus.missing_cnt  = r_ms;
endmodule

// File: tb/tb_aes_stim_seq.sv
// tb_aes_stim_seq: directed self-checking bench for aes_stim_seq
module tb_aes_stim_seq;
  localparam int L  = 10;
  localparam int L2 = 2;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  aes_stim_seq_if #(.KEY_SIZE(128), .CNT_W(16)) bus ();
  aes_stim_seq_if #(.KEY_SIZE(128), .CNT_W(4)) bus2 ();
  aes_stim_seq #(.KEY_SIZE(128), .LATENCY(L), .FLIP_KEY(1), .AVAL_MIN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus));
  aes_stim_seq #(.KEY_SIZE(128), .LATENCY(L2), .FLIP_KEY(1), .AVAL_MIN(32), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus2));
  int errors = 0;
  int checks = 0;
  // cipher stand-in: FIPS-197 vector answered exactly, everything else through a strong mixer
  function automatic logic [63:0] fmix(input logic [63:0] x);
    x = x ^ (x >> 33);
    x = x * 64'hff51afd7ed558ccd;
    x = x ^ (x >> 33);
    x = x * 64'hc4ceb9fe1a85ec53;
    return x ^ (x >> 33);
  endfunction
  function automatic logic [127:0] aes_like(input logic [127:0] p, input logic [127:0] k);
    logic [63:0] a, b;
    if (p == FP && k == FK) return FC;
    a = p[63:0] ^ k[127:64];
    b = p[127:64] ^ k[63:0];
    for (int r = 0; r < 4; r++) begin
      a = fmix(a ^ {b[31:0], b[63:32]} ^ 64'(r + 1));
      b = fmix(b ^ a);
    end
    return {a, b};
  endfunction
  // mode 0 correct, 1 bit0 corrupted, 2 constant output, 3 drop one result
  logic [1:0] mode = 2'd0;
  logic spur = 1'b0;
  int nout;
  int drop_at = -1;
  logic mq_v [L];
  logic [127:0] mq_d [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) mq_v[i] <= 1'b0;
      nout <= 0;
    end else begin
      for (int i = L - 1; i > 0; i--) begin
        mq_v[i] <= mq_v[i-1] & ~bus.dut_flush;
        mq_d[i] <= mq_d[i-1];
      end
      mq_v[0] <= bus.dut_valid;
      mq_d[0] <= aes_like(bus.dut_plain, bus.dut_key);
      if (mq_v[L-1]) nout <= nout + 1;
    end
  end
  assign bus.res_valid = spur | (mq_v[L-1] & !(mode == 2'd3 && nout == drop_at));
  assign bus.res_data  = spur ? 128'hdeadbeef : mode == 2'd1 ? mq_d[L-1] ^ 128'd1 :
                         mode == 2'd2 ? 128'h0123456789abcdef0123456789abcdef : mq_d[L-1];
  logic [L2-1:0] m2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m2 <= '0;
    else m2 <= {m2[L2-2:0], bus2.dut_valid};
  end
  assign bus2.res_valid = m2[L2-1];
  assign bus2.res_data  = '0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_dir(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd_type = 1'b0;
    bus.cmd_plain = p;
    bus.cmd_key = k;
    bus.cmd_cipher = c;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic run_seeded(input logic [127:0] p, input logic [127:0] k, input logic garbage,
                            output int nflush, output int nvalid, output int ndone, output int nbad);
    logic [127:0] one, ep, ek;
    one = 128'd1;
    nflush = 0;
    nvalid = 0;
    ndone = 0;
    nbad = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_type = 1'b1;
    bus.cmd_plain = p;
    bus.cmd_key = k;
    tick();
    bus.cmd_valid = garbage;
    bus.cmd_type = 1'b0;
    bus.cmd_plain = ~p;
    bus.cmd_key = ~k;
    for (int c = 0; c < 2000 && ndone == 0; c++) begin
      if (bus.dut_flush) nflush++;
      if (bus.dut_flush && bus.dut_valid) nbad++;
      if (bus.dut_valid) begin
        ep = p;
        ek = k;
        if (nvalid >= 1 && nvalid <= 128) ep = p ^ (one << (nvalid - 1));
        else if (nvalid > 128) ek = k ^ (one << (nvalid - 129));
        if (bus.dut_plain !== ep || bus.dut_key !== ek) nbad++;
        if (bus.cmd_ready !== 1'b0) nbad++;
        nvalid++;
      end
      if (bus.done) begin
        ndone++;
        bus.cmd_valid = 1'b0;
      end else tick();
    end
  endtask
  initial begin
    int nf, nv, nd, nb;
    bus.cmd_valid = 1'b0;
    bus.cmd_type = 1'b0;
    bus.cmd_plain = '0;
    bus.cmd_key = '0;
    bus.cmd_cipher = '0;
    bus.stat_clear = 1'b0;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_type = 1'b0;
    bus2.cmd_plain = FP;
    bus2.cmd_key = FK;
    bus2.cmd_cipher = FC;
    bus2.stat_clear = 1'b0;
    tick();
    tick();
    chk("rst_ready", 128'(bus.cmd_ready), 128'(0));
    chk("rst_valid", 128'(bus.dut_valid), 128'(0));
    chk("rst_flush", 128'(bus.dut_flush), 128'(0));
    chk("rst_plain", bus.dut_plain, '0);
    chk("rst_key", bus.dut_key, '0);
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_cnts", 128'({bus.mismatch_cnt, bus.weak_cnt, bus.missing_cnt}), '0);
    rst_n = 1'b1;
    tick();
    chk("ready_idle", 128'(bus.cmd_ready), 128'(1));
    send_dir(FP, FK, FC);
    chk("dir_valid", 128'(bus.dut_valid), 128'(1));
    chk("dir_plain", bus.dut_plain, FP);
    chk("dir_key", bus.dut_key, FK);
    tick();
    chk("dir_valid_drop", 128'(bus.dut_valid), 128'(0));
    chk("dir_busy", 128'(bus.busy), 128'(1));
    repeat (L + 2) tick();
    chk("dir_ok_cnts", 128'({bus.mismatch_cnt, bus.weak_cnt, bus.missing_cnt}), '0);
    chk("dir_idle_busy", 128'(bus.busy), 128'(0));
    mode = 2'd1;
    send_dir(FP, FK, FC);
    repeat (L) tick();
    chk("mis_before", 128'(bus.mismatch_cnt), 128'(0));
    tick();
    chk("mis_at_L+1", 128'(bus.mismatch_cnt), 128'(1));
    mode = 2'd0;
    repeat (3) tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_type = 1'b0;
    bus.cmd_plain = FP;
    bus.cmd_key = FK;
    bus.cmd_cipher = FC;
    tick();
    chk("b2b_p0", bus.dut_plain, FP);
    bus.cmd_cipher = ~FC;
    tick();
    chk("b2b_v1", 128'(bus.dut_valid), 128'(1));
    bus.cmd_plain = PS;
    bus.cmd_key = KS;
    bus.cmd_cipher = aes_like(PS, KS);
    tick();
    chk("b2b_p2", bus.dut_plain, PS);
    chk("b2b_k2", bus.dut_key, KS);
    bus.cmd_valid = 1'b0;
    tick();
    chk("b2b_end", 128'(bus.dut_valid), 128'(0));
    repeat (L + 2) tick();
    chk("b2b_mis", 128'(bus.mismatch_cnt), 128'(2));
    spur = 1'b1;
    repeat (20) tick();
    spur = 1'b0;
    chk("spur_ignored", 128'({bus.mismatch_cnt, bus.weak_cnt, bus.missing_cnt}), 128'({16'd2, 16'd0, 16'd0}));
    bus.stat_clear = 1'b1;
    tick();
    bus.stat_clear = 1'b0;
    chk("clear", 128'(bus.mismatch_cnt), 128'(0));
    run_seeded(PS, KS, 1'b1, nf, nv, nd, nb);
    chk("seed_flush", 128'(nf), 128'(2));
    chk("seed_valid", 128'(nv), 128'(257));
    chk("seed_done", 128'(nd), 128'(1));
    chk("seed_vectors", 128'(nb), 128'(0));
    tick();
    chk("seed_done_pulse", 128'(bus.done), 128'(0));
    chk("seed_busy", 128'(bus.busy), 128'(0));
    chk("seed_cnts", 128'({bus.mismatch_cnt, bus.weak_cnt, bus.missing_cnt}), '0);
    mode = 2'd2;
    run_seeded(KS, PS, 1'b0, nf, nv, nd, nb);
    chk("echo_done", 128'(nd), 128'(1));
    tick();
    chk("echo_weak", 128'(bus.weak_cnt), 128'(256));
    chk("echo_other", 128'({bus.mismatch_cnt, bus.missing_cnt}), '0);
    mode = 2'd0;
    bus.stat_clear = 1'b1;
    tick();
    bus.stat_clear = 1'b0;
    drop_at = nout + 100;
    mode = 2'd3;
    run_seeded(PS, KS, 1'b0, nf, nv, nd, nb);
    chk("drop_done", 128'(nd), 128'(1));
    tick();
    chk("drop_missing", 128'(bus.missing_cnt), 128'(1));
    chk("drop_weak", 128'(bus.weak_cnt), 128'(0));
    mode = 2'd0;
    drop_at = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_type = 1'b1;
    bus.cmd_plain = PS;
    bus.cmd_key = KS;
    tick();
    bus.cmd_valid = 1'b0;
    nv = 0;
    for (int c = 0; c < 500; c++) begin
      if (bus.dut_valid) begin
        if (nv == 51) break;
        nv++;
      end
      tick();
    end
    chk("abort_point", bus.dut_plain, PS ^ (128'd1 << 50));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(bus.dut_valid), 128'(0));
    chk("abort_plain", bus.dut_plain, '0);
    chk("abort_ready", 128'(bus.cmd_ready), 128'(0));
    chk("abort_flags", 128'({bus.dut_flush, bus.busy, bus.done}), '0);
    chk("abort_cnts", 128'({bus.mismatch_cnt, bus.weak_cnt, bus.missing_cnt}), '0);
    tick();
    chk("abort_no_done", 128'(bus.done), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("abort_ready_after", 128'(bus.cmd_ready), 128'(1));
    chk("abort_no_done2", 128'(bus.done), 128'(0));
    send_dir(FP, FK, FC);
    chk("post_dir_valid", 128'(bus.dut_valid), 128'(1));
    repeat (L + 2) tick();
    chk("post_dir_cnts", 128'({bus.mismatch_cnt, bus.weak_cnt, bus.missing_cnt}), '0);
    chk("post_dir_busy", 128'(bus.busy), 128'(0));
    bus2.cmd_valid = 1'b1;
    repeat (17) tick();
    bus2.cmd_valid = 1'b0;
    repeat (L2 + 3) tick();
    chk("sat_mis", 128'(bus2.mismatch_cnt), 128'(15));
    bus2.cmd_valid = 1'b1;
    tick();
    bus2.cmd_valid = 1'b0;
    repeat (L2) tick();
    chk("sat_hold", 128'(bus2.mismatch_cnt), 128'(15));
    bus2.stat_clear = 1'b1;
    tick();
    bus2.stat_clear = 1'b0;
    chk("clear_wins", 128'(bus2.mismatch_cnt), 128'(0));
    repeat (2) tick();
    chk("clear_stays", 128'(bus2.mismatch_cnt), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
